// File: rtl/axis_pkt_framer_if.sv
// rtl/axis_pkt_framer_if.sv - 32-bit AXI-Stream bundle used on both framer ports
//
// Purpose: groups one AXI-Stream link (data, byte strobes, last, valid, ready).
// Signals:
//   tdata  [31:0]  payload or header word
//   tstrb  [3:0]   byte strobes
//   tlast          final word of a packet
//   tvalid         source has a word
//   tready         sink accepts the word
// Modports: master drives the stream and receives tready; slave is the mirror.

interface axis_pkt_framer_if;
   logic [31:0] tdata;
   logic [3:0]  tstrb;
   logic        tlast;
   logic        tvalid;
   logic        tready;

   modport master (output tdata, output tstrb, output tlast, output tvalid, input tready);
   modport slave  (input tdata, input tstrb, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_pkt_framer.sv
// rtl/axis_pkt_framer.sv - store-and-forward packet framer with header insertion
//
// Purpose: buffers one packet of 32-bit words, then emits a header word
// {4'hA, trunc, 3'b000, seq, word_cnt[15:0]} followed by the buffered payload.
// A packet closes on input tlast or when the buffer holds 2^ADDR_W words.
// Ports:
//   s00_axis_aclk     clock for both streams
//   s00_axis_aresetn  asynchronous active-low reset
//   s00_axis          input stream (slave modport)
//   m00_axis          output stream (master modport)
//   busy              high while emitting header or payload
//   seq_num           sequence number the next header will carry

module axis_pkt_framer #(
   parameter int ADDR_W = 8
) (
   input  logic                     s00_axis_aclk,
   input  logic                     s00_axis_aresetn,
   axis_pkt_framer_if.slave         s00_axis,
   axis_pkt_framer_if.master        m00_axis,
   output logic                     busy,
   output logic [7:0]               seq_num
);

   localparam int MAX_WORDS = 1 << ADDR_W;

   typedef enum logic [1:0] {FILL, HDR, DRAIN} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   wr_ptr;
   logic [ADDR_W-1:0]   rd_ptr;
   logic [ADDR_W:0]     word_cnt;
   logic                trunc;
   logic [7:0]          seq;
   logic [35:0]         buf_mem [MAX_WORDS];

   logic                s_hs;
   logic                closing;
   logic                rd_last;
   logic                s_ready;
   logic                m_valid;
   logic                m_last;
   logic [31:0]         m_data;
   logic [3:0]          m_strb;

   // Input is only ever accepted in FILL, so the handshake needs no
   // combinational path back through s_ready.
   assign s_hs    = s00_axis.tvalid && (state == FILL);
   // All-ones write pointer means this accept is word number MAX_WORDS.
   assign closing = s_hs && (s00_axis.tlast || (&wr_ptr));
   assign rd_last = ({1'b0, rd_ptr} == (word_cnt - 1'b1));

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      m_valid   = 1'b0;
      m_last    = 1'b0;
      m_data    = 32'h0;
      m_strb    = 4'h0;
      busy      = 1'b0;
      case (state)
         FILL: begin
            s_ready = 1'b1;
            if (closing) state_nxt = HDR;
         end
         HDR: begin
            busy    = 1'b1;
            m_valid = 1'b1;
            m_strb  = 4'hF;
            m_data  = {4'hA, trunc, 3'b000, seq, 16'(word_cnt)};
            if (m00_axis.tready) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy             = 1'b1;
            m_valid          = 1'b1;
            m_last           = rd_last;
            {m_strb, m_data} = buf_mem[rd_ptr];
            if (m00_axis.tready && rd_last) state_nxt = FILL;
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         word_cnt <= '0;
         trunc    <= 1'b0;
         seq      <= 8'h0;
      end else begin
         if (s_hs) begin
            // A size-closed packet wraps wr_ptr back to zero by itself.
            wr_ptr <= wr_ptr + 1'b1;
            if (closing) begin
               word_cnt <= {1'b0, wr_ptr} + 1'b1;
               trunc    <= !s00_axis.tlast;
            end
         end
         if ((state == HDR) && m00_axis.tready) begin
            seq <= seq + 1'b1;
         end
         if ((state == DRAIN) && m00_axis.tready) begin
            if (rd_last) begin
               rd_ptr <= '0;
               wr_ptr <= '0;
            end else begin
               rd_ptr <= rd_ptr + 1'b1;
            end
         end
      end
   end

   // Payload storage carries no reset; contents are only read after being written.
   always_ff @(posedge s00_axis_aclk) begin
      if (s_hs) begin
         buf_mem[wr_ptr] <= {s00_axis.tstrb, s00_axis.tdata};
      end
   end

   assign s00_axis.tready = s_ready;
   assign m00_axis.tvalid = m_valid;
   assign m00_axis.tlast  = m_last;
   assign m00_axis.tdata  = m_data;
   assign m00_axis.tstrb  = m_strb;
   assign seq_num         = seq;

endmodule

// File: tb/tb_axis_pkt_framer.sv
// tb/tb_axis_pkt_framer.sv - directed self-checking bench for axis_pkt_framer

module tb_axis_pkt_framer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       busy, busy2;
   logic [7:0] seq_num, seq_num2;

   axis_pkt_framer_if s_if ();
   axis_pkt_framer_if m_if ();
   axis_pkt_framer_if s2_if ();
   axis_pkt_framer_if m2_if ();

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int in_cyc = 0;
   int lowcnt = 0;
   int viol = 0;
   logic [36:0] q[$];
   logic [36:0] q2[$];
   int qc[$];
   logic prev_stall = 1'b0;
   logic [36:0] prev_word = '0;
   logic bp_mode = 1'b0;
   logic rdy_level = 1'b1;

   axis_pkt_framer #(.ADDR_W(8)) dut (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
      .s00_axis(s_if), .m00_axis(m_if), .busy(busy), .seq_num(seq_num));

   axis_pkt_framer #(.ADDR_W(2)) dut_small (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
      .s00_axis(s2_if), .m00_axis(m2_if), .busy(busy2), .seq_num(seq_num2));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      #2;
      if (bp_mode) m_if.tready = ~m_if.tready;
      else m_if.tready = rdy_level;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!m_if.tvalid || {m_if.tlast, m_if.tstrb, m_if.tdata} !== prev_word)) viol++;
         prev_stall = m_if.tvalid && !m_if.tready;
         prev_word  = {m_if.tlast, m_if.tstrb, m_if.tdata};
         if (m_if.tvalid && m_if.tready) begin
            q.push_back({m_if.tlast, m_if.tstrb, m_if.tdata});
            qc.push_back(cyc);
         end
         if (s_if.tvalid && s_if.tready) in_cyc = cyc;
         if (!s_if.tready) lowcnt++;
         if (m2_if.tvalid && m2_if.tready) q2.push_back({m2_if.tlast, m2_if.tstrb, m2_if.tdata});
      end
   end

   task automatic drive_word(input int which, input logic [31:0] d, input logic [3:0] st, input logic l);
      bit ok = 0;
      @(posedge clk); #2;
      if (which == 0) begin
         s_if.tdata = d; s_if.tstrb = st; s_if.tlast = l; s_if.tvalid = 1'b1;
      end else begin
         s2_if.tdata = d; s2_if.tstrb = st; s2_if.tlast = l; s2_if.tvalid = 1'b1;
      end
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if ((which == 0) ? s_if.tready : s2_if.tready) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk); #2;
      s_if.tvalid = 1'b0;
      s2_if.tvalid = 1'b0;
      total++;
      if (!ok) begin bad++; $display("FAIL drive_timeout got=no_accept exp=accept data=%h", d); end
   endtask

   task automatic wait_out(input int which, input int n);
      int t = 0;
      while (((which == 0) ? q.size() : q2.size()) < n && t < 300) begin
         @(negedge clk); #1;
         t++;
      end
      total++;
      if (((which == 0) ? q.size() : q2.size()) < n) begin
         bad++;
         $display("FAIL wait_out got=%0d exp=%0d", (which == 0) ? q.size() : q2.size(), n);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #13;
      total++; if (s_if.tready !== 1'b1) begin bad++; $display("FAIL rst_s_tready got=%b exp=1", s_if.tready); end
      total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL rst_m_tvalid got=%b exp=0", m_if.tvalid); end
      total++; if (m_if.tlast !== 1'b0) begin bad++; $display("FAIL rst_m_tlast got=%b exp=0", m_if.tlast); end
      total++; if (m_if.tdata !== 32'h0) begin bad++; $display("FAIL rst_m_tdata got=%h exp=0", m_if.tdata); end
      total++; if (m_if.tstrb !== 4'h0) begin bad++; $display("FAIL rst_m_tstrb got=%h exp=0", m_if.tstrb); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (seq_num !== 8'h0) begin bad++; $display("FAIL rst_seq got=%h exp=0", seq_num); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      logic [36:0] exp [5];
      exp = '{{1'b0, 4'hF, 32'hA0000004}, {1'b0, 4'hF, 32'h11111111}, {1'b0, 4'hF, 32'h22222222},
              {1'b0, 4'hF, 32'h33333333}, {1'b1, 4'hF, 32'h44444444}};
      q.delete(); qc.delete(); lowcnt = 0;
      for (int i = 0; i < 4; i++) drive_word(0, 32'(32'h11111111 * (i + 1)), 4'hF, i == 3);
      wait_out(0, 5);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (q[i] !== exp[i]) begin bad++; $display("FAIL basic_word%0d got=%h exp=%h", i, q[i], exp[i]); end
         total++;
         if (qc[i] != qc[0] + i) begin bad++; $display("FAIL basic_cycle%0d got=%0d exp=%0d", i, qc[i], qc[0] + i); end
      end
      total++; if (qc[0] != in_cyc + 1) begin bad++; $display("FAIL basic_hdr_latency got=%0d exp=%0d", qc[0], in_cyc + 1); end
      total++; if (lowcnt != 5) begin bad++; $display("FAIL basic_tready_low got=%0d exp=5", lowcnt); end
      total++; if (s_if.tready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b%b exp=10", s_if.tready, busy); end
      total++; if (seq_num !== 8'd1) begin bad++; $display("FAIL basic_seq got=%0d exp=1", seq_num); end
   endtask

   task automatic test_trunc;
      logic [36:0] exp [9];
      exp = '{{1'b0, 4'hF, 32'hA8000004}, {1'b0, 4'hF, 32'hB0}, {1'b0, 4'hF, 32'hB1}, {1'b0, 4'hF, 32'hB2},
              {1'b1, 4'hF, 32'hB3}, {1'b0, 4'hF, 32'hA0010003}, {1'b0, 4'hF, 32'hB4}, {1'b0, 4'hF, 32'hB5},
              {1'b1, 4'hF, 32'hB6}};
      q2.delete();
      for (int i = 0; i < 6; i++) drive_word(1, 32'(32'hB0 + i), 4'hF, 1'b0);
      wait_out(1, 5);
      repeat (2) @(negedge clk);
      total++; if (q2.size() != 5) begin bad++; $display("FAIL trunc_count got=%0d exp=5", q2.size()); end
      total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL trunc_busy got=%b exp=0", busy2); end
      drive_word(1, 32'hB6, 4'hF, 1'b1);
      wait_out(1, 9);
      for (int i = 0; i < 9; i++) begin
         total++;
         if (q2[i] !== exp[i]) begin bad++; $display("FAIL trunc_word%0d got=%h exp=%h", i, q2[i], exp[i]); end
      end
   endtask

   task automatic test_backpressure;
      q.delete(); qc.delete(); viol = 0;
      bp_mode = 1'b1;
      for (int i = 0; i < 8; i++) drive_word(0, 32'(32'hC0 + i), 4'hF, i == 7);
      wait_out(0, 9);
      bp_mode = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (q.size() != 9) begin bad++; $display("FAIL bp_handshakes got=%0d exp=9", q.size()); end
      total++; if (q[0] !== {1'b0, 4'hF, 32'hA0010008}) begin bad++; $display("FAIL bp_hdr got=%h exp=%h", q[0], {1'b0, 4'hF, 32'hA0010008}); end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (q[i+1] !== {i == 7, 4'hF, 32'(32'hC0 + i)})
            begin bad++; $display("FAIL bp_word%0d got=%h exp=%h", i, q[i+1], {i == 7, 4'hF, 32'(32'hC0 + i)}); end
      end
      total++; if (viol != 0) begin bad++; $display("FAIL bp_stall_stable got=%0d exp=0", viol); end
   endtask

   task automatic test_strb;
      q.delete();
      drive_word(0, 32'hD0, 4'h3, 1'b0);
      drive_word(0, 32'hD1, 4'h1, 1'b1);
      wait_out(0, 3);
      total++; if (q[0] !== {1'b0, 4'hF, 32'hA0020002}) begin bad++; $display("FAIL strb_hdr got=%h exp=%h", q[0], {1'b0, 4'hF, 32'hA0020002}); end
      total++; if (q[1] !== {1'b0, 4'h3, 32'hD0}) begin bad++; $display("FAIL strb_w0 got=%h exp=%h", q[1], {1'b0, 4'h3, 32'hD0}); end
      total++; if (q[2] !== {1'b1, 4'h1, 32'hD1}) begin bad++; $display("FAIL strb_w1 got=%h exp=%h", q[2], {1'b1, 4'h1, 32'hD1}); end
   endtask

   task automatic test_reset_mid_drain;
      int t = 0;
      q.delete();
      for (int i = 0; i < 5; i++) drive_word(0, 32'(32'hE0 + i), 4'hF, i == 4);
      while (q.size() < 3 && t < 100) begin @(negedge clk); #1; t++; end
      @(posedge clk); #2;
      total++; if (q[0] !== {1'b0, 4'hF, 32'hA0030005}) begin bad++; $display("FAIL mid_hdr got=%h exp=%h", q[0], {1'b0, 4'hF, 32'hA0030005}); end
      total++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'hE2) begin bad++; $display("FAIL mid_third got=%b/%h exp=1/e2", m_if.tvalid, m_if.tdata); end
      rst_n = 1'b0;
      #1;
      total++; if (m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl got=%b%b exp=00", m_if.tvalid, m_if.tlast); end
      total++; if (m_if.tdata !== 32'h0 || m_if.tstrb !== 4'h0) begin bad++; $display("FAIL mid_rst_data got=%h/%h exp=0/0", m_if.tdata, m_if.tstrb); end
      total++; if (busy !== 1'b0 || s_if.tready !== 1'b1) begin bad++; $display("FAIL mid_rst_state got=%b%b exp=01", busy, s_if.tready); end
      total++; if (seq_num !== 8'h0) begin bad++; $display("FAIL mid_rst_seq got=%h exp=0", seq_num); end
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      for (int i = 0; i < 3; i++) drive_word(0, 32'(32'hF0 + i), 4'hF, i == 2);
      wait_out(0, 4);
      total++; if (q[0] !== {1'b0, 4'hF, 32'hA0000003}) begin bad++; $display("FAIL mid_next_hdr got=%h exp=%h", q[0], {1'b0, 4'hF, 32'hA0000003}); end
      total++; if (q[3] !== {1'b1, 4'hF, 32'hF2}) begin bad++; $display("FAIL mid_next_last got=%h exp=%h", q[3], {1'b1, 4'hF, 32'hF2}); end
   endtask

   task automatic test_seq_wrap;
      logic [36:0] eh;
      @(posedge clk); #2;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 257; k++) begin
         q.delete();
         drive_word(0, 32'(k), 4'hF, 1'b1);
         wait_out(0, 2);
         eh = {1'b0, 4'hF, 4'hA, 1'b0, 3'b000, 8'(k), 16'd1};
         total++; if (q[0] !== eh) begin bad++; $display("FAIL wrap_hdr%0d got=%h exp=%h", k, q[0], eh); end
         total++; if (q[1] !== {1'b1, 4'hF, 32'(k)}) begin bad++; $display("FAIL wrap_pay%0d got=%h exp=%h", k, q[1], {1'b1, 4'hF, 32'(k)}); end
      end
      repeat (2) @(negedge clk);
      total++; if (seq_num !== 8'd1) begin bad++; $display("FAIL wrap_seq_end got=%0d exp=1", seq_num); end
   endtask

   initial begin
      s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tstrb = '0; s_if.tlast = 1'b0;
      s2_if.tvalid = 1'b0; s2_if.tdata = '0; s2_if.tstrb = '0; s2_if.tlast = 1'b0;
      m_if.tready = 1'b1;
      m2_if.tready = 1'b1;
      test_reset();
      test_basic();
      test_trunc();
      test_backpressure();
      test_strb();
      test_reset_mid_drain();
      test_seq_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
